irda_break_idle_det: RTL and testbench
======================================

# irda_break_idle_det

Parametrised line-condition detector for the IrDA receive path, succeeding the fixed 7-ones MIR break detector. It counts consecutive '1' bits on the decoded receive bit stream, qualified by a bit-enable strobe. It reports three things: a break (abort) once a programmable run length is reached, an idle-link condition once a second, longer threshold is reached, and the end of the condition. A saturating break-event counter is provided for the status registers. Serves MIR and FIR receive channels; thresholds are driven from control registers.

## Interface
- CNT_W, 4 — width of run counter and threshold inputs; run counter saturates at 2^CNT_W-1
- EVT_W, 8 — width of break-event counter
- RX_INV, 0 — 1: rx_i inverted before counting (counts runs of '0')

- clk  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- clr_i  in  1  synchronous clear of counters and FSM
- bit_en_i  in  1  one-clk strobe marking a valid rx_i bit
- rx_i  in  1  decoded receive bit
- brk_len_i  in  CNT_W  break threshold in bits; 0 disables break detection
- idle_len_i  in  CNT_W  idle threshold in bits; 0 disables idle detection
- brd_o  out  1  one-clk pulse, break detected
- brk_end_o  out  1  one-clk pulse, break/idle condition ended
- brk_active_o  out  1  level, break or idle in progress
- idle_o  out  1  level, idle condition
- run_cnt_o  out  CNT_W  current consecutive-ones count
- brk_cnt_o  out  EVT_W  number of breaks detected, saturating

## Operation
- Effective bit b = rx_i ^ RX_INV. All state changes occur only on clk edges with bit_en_i=1, except clr_i.
- Run counter: b=0 → 0; b=1 → count+1, saturating at 2^CNT_W-1. Call the value after update n.
- FSM states: ST_NONE, ST_BRK, ST_IDLE.
  - Break hit when brk_len_i≠0 and n≥brk_len_i. Idle hit when idle_len_i≠0 and n≥idle_len_i. Both use ≥, so a threshold lowered mid-run takes effect on the next bit.
  - ST_NONE: idle hit → ST_IDLE, and brd_o pulses if break is also hit. Otherwise break hit → ST_BRK with brd_o pulse.
  - ST_BRK: b=0 → ST_NONE with brk_end_o pulse. Otherwise idle hit → ST_IDLE.
  - ST_IDLE: b=0 → ST_NONE with brk_end_o pulse.
  - Re-detection requires passing through ST_NONE, i.e. a '0' bit. A saturated counter therefore does not re-trigger.
- brk_cnt_o increments on each brd_o pulse and saturates at 2^EVT_W-1.
- brk_active_o = (state≠ST_NONE). idle_o = (state=ST_IDLE).
- clr_i=1 has priority over bit_en_i. It zeroes run counter, brk_cnt_o and state, and produces no pulse on brd_o or brk_end_o.

## Timing
- All outputs are registered. Reset values: brd_o=0, brk_end_o=0, brk_active_o=0, idle_o=0, run_cnt_o=0, brk_cnt_o=0, state ST_NONE.
- Latency:
  - brd_o is high in the clk cycle after the edge that samples the threshold bit. It is high for exactly one clk, regardless of bit_en_i spacing.
  - brk_active_o, idle_o and run_cnt_o update on that same edge.
  - brk_end_o is high one clk after the edge sampling the terminating '0'.
- bit_en_i back-to-back (every clk) is legal. A pulse and a new qualifying bit on consecutive clks is handled without loss.
- Reset asserted mid-run clears everything immediately. No pulse is emitted on deassertion.
- brk_len_i/idle_len_i are sampled combinationally at each enabled edge. No shadow register.

## Structure
- Package irda_det_pkg: state encoding constants (ST_NONE=2'd0, ST_BRK=2'd1, ST_IDLE=2'd2), default CNT_W/EVT_W values.
- Sub-module irda_sat_cnt (parametric width, inc/clr/en, saturating), instantiated twice: run counter and event counter.
- Top holds FSM, threshold compare and pulse registers.

## Test plan
- brk_len=7, idle_len=0, bit_en every 4 clks, rx=0 then seven 1s → brd_o one-clk pulse after 7th bit, brk_active_o=1, brk_cnt_o=1. A following 0 → brk_end_o pulse, brk_active_o=0.
- brk_len=7, six 1s then 0, repeated → no brd_o, run_cnt_o returns to 0 each time, brk_cnt_o=0.
- brk_len=4, idle_len=12, sixteen 1s → brd_o after bit 4, idle_o=1 after bit 12, run_cnt_o saturates at 15 with no further pulses. Then 0 → single brk_end_o.
- idle_len=3, brk_len=5, three 1s → ST_IDLE directly with no brd_o. Second case, idle_len=brk_len=3 → brd_o and idle_o on the same bit.
- Mid-run (count=5, brk_len=8): brk_len lowered to 4 → brd_o after the next 1. Separately, clr_i during ST_BRK → all outputs 0 next clk, no brk_end_o.
- brk_cnt_o at 255 (EVT_W=8) plus one more break → stays 255. RX_INV=1 with zero runs → same detections as the non-inverted case.

Source files
------------

// File: rtl/irda_det_pkg.sv
// irda_det_pkg
//   Shared definitions for the IrDA receive-path break/idle line detector:
//   FSM state encoding and default widths for the run and event counters.
package irda_det_pkg;

  localparam int DEF_CNT_W = 4;
  localparam int DEF_EVT_W = 8;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_BRK  = 2'd1,
    ST_IDLE = 2'd2
  } det_state_e;

endpackage

// File: rtl/irda_sat_cnt.sv
// irda_sat_cnt
//   Saturating up-counter with synchronous clear and an enable-qualified
//   increment / zero operation.
// Ports:
//   clk, wb_rst_i  clock, asynchronous active-high reset
//   clr_i          synchronous clear (priority over en_i)
//   en_i           update strobe
//   inc_i          with en_i: 1 = increment (saturating), 0 = zero the count
//   cnt_o          registered count
//   cnt_nxt_o      value the count takes on the coming edge
module irda_sat_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         wb_rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_nxt_o
);

  // The next value is exported so the owner can compare against the
  // post-update count on the same edge that stores it.
  always_comb begin
    cnt_nxt_o = cnt_o;
    if (clr_i) begin
      cnt_nxt_o = '0;
    end else if (en_i) begin
      if (!inc_i) begin
        cnt_nxt_o = '0;
      end else if (cnt_o != {W{1'b1}}) begin
        cnt_nxt_o = cnt_o + W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_o <= '0;
    end else begin
      cnt_o <= cnt_nxt_o;
    end
  end

endmodule

// File: rtl/irda_break_idle_det.sv
// irda_break_idle_det
//   Counts consecutive '1' bits (or '0' bits when RX_INV=1) on the decoded
//   IrDA receive stream and flags break and idle-link conditions against
//   programmable run-length thresholds.
// Ports:
//   clk, wb_rst_i  clock, asynchronous active-high reset
//   clr_i          synchronous clear of counters and FSM, no pulses
//   bit_en_i       one-clk strobe qualifying rx_i
//   rx_i           decoded receive bit
//   brk_len_i      break threshold in bits (0 disables)
//   idle_len_i     idle threshold in bits (0 disables)
//   brd_o          one-clk pulse, break detected
//   brk_end_o      one-clk pulse, break/idle condition ended
//   brk_active_o   level, break or idle in progress
//   idle_o         level, idle condition
//   run_cnt_o      current run length, saturating
//   brk_cnt_o      saturating count of detected breaks
module irda_break_idle_det
  import irda_det_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int EVT_W  = DEF_EVT_W,
  parameter bit RX_INV = 1'b0
) (
  input  logic             clk,
  input  logic             wb_rst_i,
  input  logic             clr_i,
  input  logic             bit_en_i,
  input  logic             rx_i,
  input  logic [CNT_W-1:0] brk_len_i,
  input  logic [CNT_W-1:0] idle_len_i,
  output logic             brd_o,
  output logic             brk_end_o,
  output logic             brk_active_o,
  output logic             idle_o,
  output logic [CNT_W-1:0] run_cnt_o,
  output logic [EVT_W-1:0] brk_cnt_o
);

  det_state_e       state_q, state_d;
  logic             bit_val;
  logic [CNT_W-1:0] run_nxt;
  logic [EVT_W-1:0] evt_nxt_unused;
  logic             brk_hit, idle_hit;
  logic             brd_d, end_d;
  logic             brd_q, end_q;

  assign bit_val = rx_i ^ RX_INV;

  irda_sat_cnt #(.W(CNT_W)) u_run_cnt (
    .clk       (clk),
    .wb_rst_i  (wb_rst_i),
    .clr_i     (clr_i),
    .en_i      (bit_en_i),
    .inc_i     (bit_val),
    .cnt_o     (run_cnt_o),
    .cnt_nxt_o (run_nxt)
  );

  // Event counter advances on the same edge that raises brd_o, so the new
  // total is visible while the pulse is high.
  irda_sat_cnt #(.W(EVT_W)) u_evt_cnt (
    .clk       (clk),
    .wb_rst_i  (wb_rst_i),
    .clr_i     (clr_i),
    .en_i      (brd_d),
    .inc_i     (1'b1),
    .cnt_o     (brk_cnt_o),
    .cnt_nxt_o (evt_nxt_unused)
  );

  // Thresholds compare against the post-update run length with >=, so a
  // threshold lowered below the current run fires on the next qualifying bit.
  assign brk_hit  = (brk_len_i  != '0) && (run_nxt >= brk_len_i);
  assign idle_hit = (idle_len_i != '0) && (run_nxt >= idle_len_i);

  // Next-state and pulse decode; a condition can only re-arm after ST_NONE,
  // which is why a saturated run counter does not re-trigger.
  always_comb begin
    state_d = state_q;
    brd_d   = 1'b0;
    end_d   = 1'b0;
    if (clr_i) begin
      state_d = ST_NONE;
    end else if (bit_en_i) begin
      unique case (state_q)
        ST_NONE: begin
          if (idle_hit) begin
            state_d = ST_IDLE;
            brd_d   = brk_hit;
          end else if (brk_hit) begin
            state_d = ST_BRK;
            brd_d   = 1'b1;
          end
        end
        ST_BRK: begin
          if (!bit_val) begin
            state_d = ST_NONE;
            end_d   = 1'b1;
          end else if (idle_hit) begin
            state_d = ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (!bit_val) begin
            state_d = ST_NONE;
            end_d   = 1'b1;
          end
        end
        default: state_d = ST_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_NONE;
      brd_q   <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      brd_q   <= brd_d;
      end_q   <= end_d;
    end
  end

  assign brd_o        = brd_q;
  assign brk_end_o    = end_q;
  assign brk_active_o = (state_q != ST_NONE);
  assign idle_o       = (state_q == ST_IDLE);

endmodule

// File: tb/tb_irda_break_idle_det.sv
// tb_irda_break_idle_det
//   Drives a non-inverted and an inverted (RX_INV=1) instance with the same
//   directed bit sequence (complemented for the inverted one). Expected
//   pulses are queued per instance and popped by a monitor whenever an
//   instance shows brd_o or brk_end_o; levels are compared after each step.
module tb_irda_break_idle_det;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic       clr_i;
  logic       bit_en_i;
  logic       rx0, rx1;
  logic [3:0] brk_len, idle_len;

  logic       brd0, end0, act0, idle0;
  logic       brd1, end1, act1, idle1;
  logic [3:0] run0, run1;
  logic [7:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];

  always #5 clk = ~clk;

  irda_break_idle_det #(.CNT_W(4), .EVT_W(8), .RX_INV(1'b0)) dut0 (
    .clk(clk), .wb_rst_i(wb_rst_i), .clr_i(clr_i), .bit_en_i(bit_en_i),
    .rx_i(rx0), .brk_len_i(brk_len), .idle_len_i(idle_len),
    .brd_o(brd0), .brk_end_o(end0), .brk_active_o(act0), .idle_o(idle0),
    .run_cnt_o(run0), .brk_cnt_o(cnt0)
  );

  irda_break_idle_det #(.CNT_W(4), .EVT_W(8), .RX_INV(1'b1)) dut1 (
    .clk(clk), .wb_rst_i(wb_rst_i), .clr_i(clr_i), .bit_en_i(bit_en_i),
    .rx_i(rx1), .brk_len_i(brk_len), .idle_len_i(idle_len),
    .brd_o(brd1), .brk_end_o(end1), .brk_active_o(act1), .idle_o(idle1),
    .run_cnt_o(run1), .brk_cnt_o(cnt1)
  );

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse monitors: every brd_o/brk_end_o cycle must match the queue head.
  always @(negedge clk) begin
    if (!wb_rst_i && (brd0 || end0)) begin
      if (q0.size() == 0) begin
        checkVal("dut0 unexpected pulse {brd,end}", int'({brd0, end0}), 0);
      end else begin
        checkVal("dut0 pulse {brd,end}", int'({brd0, end0}), int'(q0.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!wb_rst_i && (brd1 || end1)) begin
      if (q1.size() == 0) begin
        checkVal("dut1 unexpected pulse {brd,end}", int'({brd1, end1}), 0);
      end else begin
        checkVal("dut1 pulse {brd,end}", int'({brd1, end1}), int'(q1.pop_front()));
      end
    end
  end

  // Called at posedge+1; presents one bit for one clk then leaves gap-1
  // quiet clocks. Consecutive calls with gap=1 give back-to-back bits.
  task automatic applyStimulus(input logic rx, input logic expBrd,
                               input logic expEnd, input int gap);
    if (expBrd || expEnd) begin
      q0.push_back({expBrd, expEnd});
      q1.push_back({expBrd, expEnd});
    end
    rx0      = rx;
    rx1      = ~rx;
    bit_en_i = 1'b1;
    @(posedge clk); #1;
    bit_en_i = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic active,
                             input logic idle, input int run, input int cnt);
    checkVal({name, " dut0 active"}, int'(act0), int'(active));
    checkVal({name, " dut0 idle"},   int'(idle0), int'(idle));
    checkVal({name, " dut0 run"},    int'(run0), run);
    checkVal({name, " dut0 brkcnt"}, int'(cnt0), cnt);
    checkVal({name, " dut1 active"}, int'(act1), int'(active));
    checkVal({name, " dut1 idle"},   int'(idle1), int'(idle));
    checkVal({name, " dut1 run"},    int'(run1), run);
    checkVal({name, " dut1 brkcnt"}, int'(cnt1), cnt);
  endtask

  task automatic doClear();
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
  endtask

  initial begin
    wb_rst_i = 1'b1;
    clr_i    = 1'b0;
    bit_en_i = 1'b0;
    rx0      = 1'b0;
    rx1      = 1'b1;
    brk_len  = 4'd0;
    idle_len = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    wb_rst_i = 1'b0;
    checkOutput("reset", 1'b0, 1'b0, 0, 0);
    checkVal("reset dut0 pulses", int'({brd0, end0}), 0);
    checkVal("reset dut1 pulses", int'({brd1, end1}), 0);

    // Basic 7-bit break, bits every 4 clocks
    brk_len = 4'd7;
    applyStimulus(1'b0, 1'b0, 1'b0, 4);
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 4);
    checkOutput("six ones", 1'b0, 1'b0, 6, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4);
    checkOutput("brk7 hit", 1'b1, 1'b0, 7, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4);
    checkOutput("brk7 end", 1'b0, 1'b0, 0, 1);

    // Six ones then zero, twice: never reaches threshold
    doClear();
    checkOutput("clear", 1'b0, 1'b0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 2);
      checkOutput("short run", 1'b0, 1'b0, 6, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 2);
      checkOutput("short run zero", 1'b0, 1'b0, 0, 0);
    end

    // Break at 4, idle at 12, sixteen back-to-back ones, saturation at 15
    brk_len  = 4'd4;
    idle_len = 4'd12;
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, (i == 4), 1'b0, 1);
      if (i == 4)  checkOutput("brk4", 1'b1, 1'b0, 4, 1);
      if (i == 11) checkOutput("pre idle", 1'b1, 1'b0, 11, 1);
      if (i == 12) checkOutput("idle12", 1'b1, 1'b1, 12, 1);
    end
    checkOutput("saturated", 1'b1, 1'b1, 15, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 2);
    checkOutput("idle end", 1'b0, 1'b0, 0, 1);

    // Idle threshold below break threshold: straight to idle, no break
    doClear();
    idle_len = 4'd3;
    brk_len  = 4'd5;
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 2);
    checkOutput("idle first", 1'b1, 1'b1, 3, 0);
    for (int i = 4; i <= 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 2);
    checkOutput("idle no brk", 1'b1, 1'b1, 5, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2);

    // Equal thresholds: break and idle on the same bit
    brk_len = 4'd3;
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, (i == 3), 1'b0, 2);
    checkOutput("brk+idle", 1'b1, 1'b1, 3, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 2);

    // Threshold lowered mid-run takes effect on the next one
    idle_len = 4'd0;
    brk_len  = 4'd8;
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 3);
    checkOutput("mid run", 1'b0, 1'b0, 5, 1);
    brk_len = 4'd4;
    applyStimulus(1'b1, 1'b1, 1'b0, 3);
    checkOutput("lowered brk", 1'b1, 1'b0, 6, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 3);

    // Clear during ST_BRK: everything zero, no end pulse
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, (i == 4), 1'b0, 2);
    checkOutput("pre clr", 1'b1, 1'b0, 4, 3);
    doClear();
    checkOutput("clr in brk", 1'b0, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;

    // Both thresholds disabled: long run with no detection
    brk_len  = 4'd0;
    idle_len = 4'd0;
    for (int i = 1; i <= 17; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("disabled", 1'b0, 1'b0, 15, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);

    // Asynchronous reset mid-run clears at once, no pulse afterwards
    brk_len = 4'd4;
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1);
    #2 wb_rst_i = 1'b1;
    #1;
    checkOutput("async reset", 1'b0, 1'b0, 0, 0);
    @(posedge clk); #1;
    wb_rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back break/end pairs with brk_len=1, event counter saturation
    brk_len = 4'd1;
    for (int i = 1; i <= 256; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      if (i == 2)   checkOutput("evt 2", 1'b0, 1'b0, 0, 2);
      if (i == 255) checkOutput("evt 255", 1'b0, 1'b0, 0, 255);
    end
    checkOutput("evt sat", 1'b0, 1'b0, 0, 255);

    repeat (4) @(posedge clk);
    #1;
    checkVal("dut0 pending pulses", q0.size(), 0);
    checkVal("dut1 pending pulses", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
